// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB-to-GPIO register bridge: FSM state
// encoding, GPIO register offsets and the access legality check.
package apb_gpio_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RDY  = 3'd3,
        ERR  = 3'd4
    } apb_state_e;

    // Byte offsets of the GPIO register file
    localparam logic [31:0] RGPIO_IN    = 32'h00;
    localparam logic [31:0] RGPIO_OUT   = 32'h04;
    localparam logic [31:0] RGPIO_OE    = 32'h08;
    localparam logic [31:0] RGPIO_INTE  = 32'h0C;
    localparam logic [31:0] RGPIO_PTRIG = 32'h10;
    localparam logic [31:0] RGPIO_AUX   = 32'h14;
    localparam logic [31:0] RGPIO_CTRL  = 32'h18;
    localparam logic [31:0] RGPIO_INTS  = 32'h1C;
    localparam logic [31:0] RGPIO_ECLK  = 32'h20;
    localparam logic [31:0] RGPIO_NEC   = 32'h24;

    // RGPIO_IN reflects the pins, so it cannot be written
    function automatic logic apb_illegal(input logic [31:0] addr, input logic wr);
        return (addr[1:0] != 2'b00) || (addr > RGPIO_NEC) || (wr && (addr == RGPIO_IN));
    endfunction

endpackage

// File: rtl/apb_gpio_ctrl.sv
// APB slave front-end for the GPIO register file: zero-wait writes,
// RD_WAIT+1 wait-state reads, and an error response for illegal accesses.
module apb_gpio_ctrl
    import apb_gpio_pkg::*;
#(
    parameter int unsigned RD_WAIT = 1   // 0..7
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] gpio_addr,
    output logic [31:0] gpio_dat_i,
    output logic        gpio_we,
    input  logic [31:0] gpio_dat_o
);

    localparam logic [2:0] LAST_CNT = 3'(RD_WAIT);

    apb_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic        we_c, rdy_c, err_c;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        we_c    = 1'b0;
        rdy_c   = 1'b0;
        err_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d = paddr;
                    cnt_d  = '0;
                    if (pwrite) wdat_d = pwdata;
                    if (apb_illegal(paddr, pwrite)) begin
                        state_d = ERR;
                        rdat_d  = '0;
                    end else begin
                        state_d = pwrite ? WR : RD;
                    end
                end
            end
            WR: begin
                we_c    = psel & penable;
                rdy_c   = psel;
                state_d = IDLE;
            end
            RD: begin
                // Losing psel mid-read drops the transfer without a response
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    rdat_d  = gpio_dat_o;
                    state_d = RDY;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RDY: begin
                rdy_c   = psel;
                state_d = IDLE;
            end
            ERR: begin
                rdy_c   = 1'b1;
                err_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gpio_addr  = addr_q;
    assign gpio_dat_i = wdat_q;
    assign gpio_we    = we_c;
    assign prdata     = rdat_q;
    assign pready     = rdy_c;
    assign pslverr    = err_c;

endmodule

// File: doc/apb_gpio_ctrl.md
APB_GPIO_CTRL -- requirements
Module: apb_gpio_ctrl

Interface
REQ-001 The block SHALL have one parameter: RD_WAIT, default 1, number of extra read wait cycles, legal range 0..7.
REQ-002 The block SHALL have port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port sys_rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have APB slave inputs psel (1), penable (1), pwrite (1), paddr (32) and pwdata (32).
REQ-005 The block SHALL have APB slave outputs prdata (32), pready (1) and pslverr (1).
REQ-006 The block SHALL have register-side outputs gpio_addr (32), gpio_dat_i (32) and gpio_we (1), and register-side input gpio_dat_o (32), which is combinational read data for gpio_addr.

Function
REQ-007 The block SHALL be an FSM with states IDLE, WR, RD, RDY and ERR.
REQ-008 In IDLE with psel=1 and penable=0 (SETUP), the block SHALL capture paddr into gpio_addr and, for writes only, pwdata into gpio_dat_i.
REQ-009 On that SETUP edge the next state SHALL be ERR if the access is illegal, else WR if pwrite=1, else RD.
REQ-010 An access SHALL be illegal when paddr[1:0]!=0, when paddr>0x24, or when it writes 0x00 (RGPIO_IN).
REQ-011 Legal offsets: IN 0x00, OUT 0x04, OE 0x08, INTE 0x0C, PTRIG 0x10, AUX 0x14, CTRL 0x18, INTS 0x1C, ECLK 0x20, NEC 0x24.
REQ-012 In WR, gpio_we SHALL be psel&penable; pready SHALL be 1; next state IDLE. Writes therefore have zero wait states and gpio_we is high for exactly one cycle.
REQ-013 In RD, pready SHALL be 0 for RD_WAIT+1 cycles, counted by a 3-bit counter cleared on entry.
REQ-014 On the last RD cycle edge, prdata SHALL load gpio_dat_o and the next state SHALL be RDY.
REQ-015 In RDY, pready SHALL be 1 with prdata stable; next state IDLE.
REQ-016 In ERR, pready and pslverr SHALL both be 1 for one cycle, gpio_we SHALL stay 0, and prdata SHALL be 0; next state IDLE.
REQ-017 If psel=0 in WR, RD or RDY, the block SHALL abort to IDLE with gpio_we=0 and pready=0.
REQ-018 psel=1 with penable=1 while in IDLE SHALL be ignored.
REQ-019 gpio_addr and gpio_dat_i SHALL hold their values until the next SETUP capture.
REQ-020 prdata SHALL hold its value until the next read capture or error.
REQ-021 A SETUP in the cycle immediately after pready=1 SHALL be accepted, giving back-to-back transfers of 2 cycles for writes and RD_WAIT+3 cycles for reads.
REQ-022 pready and pslverr SHALL be 0 in every state not listed above.

Reset
REQ-023 On sys_rst=0, regardless of sys_clk: state IDLE, counter 0, and gpio_addr, gpio_dat_i, prdata, gpio_we, pready and pslverr all 0.
REQ-024 Reset asserted mid-transfer SHALL abandon the transfer with no gpio_we pulse.
REQ-025 The first SETUP after sys_rst rises SHALL be accepted normally.

Structure
REQ-026 The state enum and the address-offset constants (REQ-011) SHALL live in shared package apb_gpio_pkg, with values equal to the GPIO register address defines.
REQ-027 apb_gpio_ctrl SHALL be a single module with no sub-modules; it is instantiated alongside register, driving register's gpio_addr, gpio_dat_i and gpio_we and receiving its gpio_dat_o.

Verification
REQ-028 Write OUT: write 0x04 data 0xAAAA_5555 -> gpio_we high exactly one cycle with gpio_addr=0x04 and gpio_dat_i=0xAAAA_5555; pready=1 in the first ACCESS cycle; pslverr=0.
REQ-029 Read with RD_WAIT=1: read 0x04 with gpio_dat_o=0x1234_5678 -> two cycles of pready=0, then pready=1 with prdata=0x1234_5678.
REQ-030 Illegal accesses: write 0x00, read 0x28 and read 0x06 -> each returns pready=1 and pslverr=1 in the first ACCESS cycle, gpio_we never asserted, prdata=0.
REQ-031 Back-to-back: write OE 0xFFFF_0000 then immediately read OE -> both complete, and prdata=0xFFFF_0000 when the bench models the register.
REQ-032 Abort and reset: psel dropped in the first RD cycle -> IDLE, no pready; sys_rst pulsed low during RD -> all outputs 0; the next write completes normally.
